// File: rtl/scene_buffer_pkg.sv
// Shared types for the scene buffer: default capacity and the packed scene object.
package scene_buffer_pkg;

    localparam int unsigned SCENE_BUFFER_DEPTH = 8;

    typedef struct packed {
        logic [3:0]  kind;
        logic [7:0]  material;
        logic [15:0] pos_x;
        logic [15:0] pos_y;
        logic [15:0] pos_z;
        logic [15:0] radius;
    } object_t;

endpackage

// File: rtl/scene_buffer.sv
// Scene object store between the scene loader and the ray tracer.
// Loader appends objects and commits a load with wr_last; the ray tracer reads by index with
// a fixed 2-cycle latency. Build option SCENE_BUFFER_DOUBLE_EN selects a double-buffered store
// (load into the back bank, publish on frame_sync); otherwise a single shared bank is used and
// a commit becomes visible on the following cycle.
module scene_buffer
    import scene_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SCENE_BUFFER_DEPTH,
    localparam int unsigned IW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    input  object_t       wr_obj,
    input  logic          wr_last,
    input  logic          frame_sync,
    input  logic [IW-1:0] obj_idx,
    output object_t       obj,
    output logic          obj_last,
    output logic [IW:0]   num_objs,
    output logic          scene_ready,
    output logic          overflow
);

    localparam logic [IW:0] DepthW = (IW+1)'(DEPTH);
    localparam logic [IW:0] OneW   = (IW+1)'(1);

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [IW:0]   wp_q, wp_d;
    logic [IW:0]   commit_cnt;
    logic [IW-1:0] wr_idx;
    logic          wr_store;
    logic          commit;
    logic          overflow_q, overflow_d;
    logic [IW:0]   num_q, num_d;

    // Append/drop decision, commit count and write pointer next state.
    always_comb begin
        wr_store   = wr_valid && (wp_q < DepthW);
        commit     = wr_valid && wr_last;
        // A full bank commits exactly DEPTH objects even though this object is dropped.
        commit_cnt = (wp_q == DepthW) ? DepthW : wp_q + OneW;
        wr_idx     = wp_q[IW-1:0];
        wp_d       = wp_q;
        if (commit) begin
            wp_d = '0;
        end else if (wr_store) begin
            wp_d = wp_q + OneW;
        end
        overflow_d = overflow_q | (wr_valid & ~wr_store);
    end

    // Write pointer and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Bank / visibility control
    // ------------------------------------------------------------------
`ifdef SCENE_BUFFER_DOUBLE_EN
    logic        pending_q, pending_d;
    logic        bank_q, bank_d;       // front (read) bank; back bank is ~bank_q
    logic [IW:0] load_cnt_q, load_cnt_d;

    // Commit latches the count; a later frame_sync publishes it by swapping banks.
    // A commit on a frame_sync cycle wins: the swap waits for the next frame_sync.
    always_comb begin
        pending_d  = pending_q;
        bank_d     = bank_q;
        load_cnt_d = load_cnt_q;
        num_d      = num_q;
        if (commit) begin
            pending_d  = 1'b1;
            load_cnt_d = commit_cnt;
        end else if (frame_sync && pending_q) begin
            bank_d    = ~bank_q;
            num_d     = load_cnt_q;
            pending_d = 1'b0;
        end
    end

    // Bank select, pending commit and visible count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= 1'b0;
            bank_q     <= 1'b0;
            load_cnt_q <= '0;
            num_q      <= '0;
        end else begin
            pending_q  <= pending_d;
            bank_q     <= bank_d;
            load_cnt_q <= load_cnt_d;
            num_q      <= num_d;
        end
    end

    assign scene_ready = (num_q != '0);
`else
    logic loading_q, loading_d;
    logic unused_frame_sync;

    assign unused_frame_sync = frame_sync;

    // Single bank: commit publishes the count directly; track an open load for scene_ready.
    always_comb begin
        num_d     = num_q;
        loading_d = loading_q;
        if (commit) begin
            num_d     = commit_cnt;
            loading_d = 1'b0;
        end else if (wr_valid) begin
            loading_d = 1'b1;
        end
    end

    // Visible count and load-in-progress registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q     <= '0;
            loading_q <= 1'b0;
        end else begin
            num_q     <= num_d;
            loading_q <= loading_d;
        end
    end

    // The shared bank is being overwritten while a load is open, so the scene is not ready.
    assign scene_ready = (num_q != '0) && !(loading_q || wr_valid);
`endif

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
`ifdef SCENE_BUFFER_DOUBLE_EN
    object_t mem [2][DEPTH];
`else
    object_t mem [DEPTH];
`endif
    object_t rd_data_q;

    // Memory write port; writes are suppressed while in reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_store) begin
`ifdef SCENE_BUFFER_DOUBLE_EN
            mem[~bank_q][wr_idx] <= wr_obj;
`else
            mem[wr_idx] <= wr_obj;
`endif
        end
    end

    // Stage 1 memory read; nonblocking update gives read-first on a same-address write.
    always_ff @(posedge clk) begin
`ifdef SCENE_BUFFER_DOUBLE_EN
        rd_data_q <= mem[bank_q][obj_idx];
`else
        rd_data_q <= mem[obj_idx];
`endif
    end

    // ------------------------------------------------------------------
    // Read pipeline control
    // ------------------------------------------------------------------
    logic [IW:0] idx_plus1;
    logic        last_calc;
    logic        s1_zero_q;
    logic        s1_last_q;
    object_t     obj_q;
    logic        obj_last_q;

    // Flags are judged against the count visible in the same cycle as the bank read.
    always_comb begin
        idx_plus1 = {1'b0, obj_idx} + OneW;
        last_calc = (num_q == '0) || (idx_plus1 >= num_q);
    end

    // Stage 1 control flags, flushed to the empty-scene response on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_zero_q <= 1'b1;
            s1_last_q <= 1'b1;
        end else begin
            s1_zero_q <= (num_q == '0);
            s1_last_q <= last_calc;
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            obj_q      <= '0;
            obj_last_q <= 1'b1;
        end else begin
            obj_q      <= s1_zero_q ? '0 : rd_data_q;
            obj_last_q <= s1_last_q;
        end
    end

    assign obj      = obj_q;
    assign obj_last = obj_last_q;
    assign num_objs = num_q;
    assign overflow = overflow_q;

endmodule

// File: doc/scene_buffer.md
SCENE_BUFFER -- requirements
Module: scene_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default SCENE_BUFFER_DEPTH, giving the object capacity per bank; IW = $clog2(DEPTH).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_valid  input  1  append wr_obj to the load bank this cycle.
REQ-005 SHALL have port wr_obj  input  object  object to append (shared package packed struct).
REQ-006 SHALL have port wr_last  input  1  qualified by wr_valid; this object ends the load and commits it.
REQ-007 SHALL have port frame_sync  input  1  one-cycle pulse at a frame boundary; the only point a pending scene may become visible.
REQ-008 SHALL have port obj_idx  input  IW  read index from the ray tracer.
REQ-009 SHALL have port obj  output  object  object at obj_idx, 2-cycle latency.
REQ-010 SHALL have port obj_last  output  1  high when the returned obj is the final valid object of the visible scene; aligned with obj.
REQ-011 SHALL have port num_objs  output  IW+1  object count of the visible scene.
REQ-012 SHALL have port scene_ready  output  1  visible scene holds at least one committed object.
REQ-013 SHALL have port overflow  output  1  sticky; a write was dropped because the load bank was full.

Function
REQ-014 Writes SHALL go to a write pointer wp: on wr_valid with wp<DEPTH, store at wp and increment wp; with wp==DEPTH, drop the object and set overflow.
REQ-015 On wr_valid&wr_last, the load count SHALL be min(wp+1, DEPTH), and wp SHALL return to 0 next cycle.
REQ-016 Read path SHALL be a 2-stage pipeline: stage 1 registers the memory read of obj_idx; stage 2 registers obj and obj_last. A new index SHALL be accepted every cycle.
REQ-017 obj_last SHALL be 1 when the sampled obj_idx >= num_objs-1, and also when num_objs==0.
REQ-018 When num_objs==0, obj SHALL be all zeros; scene_ready SHALL equal (num_objs!=0).
REQ-019 Reads with obj_idx >= num_objs SHALL return the memory contents at that index, with obj_last=1.
REQ-020 A write and a read of the same bank location in the same cycle SHALL return the old data (read-first).
REQ-021 num_objs, obj_last and obj SHALL change together, and SHALL stay consistent for every read issued after an update takes effect.

Reset
REQ-022 On rst: wp=0, num_objs=0, overflow=0, scene_ready=0, obj=0, obj_last=1, pending=0, bank select=0, and the pipeline is flushed; memory contents are not cleared.
REQ-023 A load in progress at rst SHALL be discarded; rst asserted concurrently with wr_last SHALL take priority.

Configuration
REQ-024 Macro SCENE_BUFFER_DOUBLE_EN defined: two banks, with writes to the back bank and reads from the front bank.
- wr_last sets pending and latches the load count.
- On the next frame_sync with pending=1, the banks swap, num_objs takes the latched count, and pending clears; the change is visible to reads sampled from the following cycle.
- frame_sync with pending=0 does nothing.
- wr_last coincident with frame_sync: the commit happens this cycle, and the swap occurs at a later frame_sync.
- A second commit before the swap SHALL overwrite the latched count.
REQ-025 Macro SCENE_BUFFER_DOUBLE_EN undefined: a single bank shared by both ports; frame_sync is ignored.
- scene_ready=0 from the first wr_valid of a load until wr_last.
- num_objs updates on the cycle after wr_last.

Verification
REQ-026 Load 3 objects A,B,C (C with wr_last), issue frame_sync if double-buffered, read idx 0,1,2 back-to-back -> B-side gets A,B,C two cycles later with obj_last 0,0,1; num_objs=3.
REQ-027 After reset, read idx 0 -> obj=0, obj_last=1, scene_ready=0.
REQ-028 Write DEPTH+2 objects, last with wr_last -> overflow=1, num_objs=DEPTH after commit, obj_last=1 at idx DEPTH-1.
REQ-029 Double: scene X (2 objects) visible; load Y (5 objects) with continuous reads, no frame_sync -> reads still X with num_objs=2; after frame_sync -> reads Y, num_objs=5.
REQ-030 Assert rst mid-load after 2 of 4 writes, then load 1 object with wr_last -> num_objs=1, overflow=0.
REQ-031 wr_last and frame_sync on the same cycle with no prior pending (double) -> num_objs unchanged; next frame_sync -> new count visible.
